// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - shared VGA timing, colour and framebuffer geometry definitions
package vga_scanout_pkg;

  // 640x480@60 Hz timing, horizontal in pixels, vertical in lines
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 50 MHz system clock -> 25 MHz pixel tick
  localparam int VGA_CLK_DIV = 2;

  // Framebuffer geometry: 40x30 cells of 16x16 pixels, row-major
  localparam int VGA_CELL_SHIFT = 4;
  localparam int VGA_COLS       = 40;
  localparam int VGA_ROWS       = 30;
  localparam int VGA_ADDR_W     = 16;

  // Counter width, large enough for any sensible H/V total
  localparam int CNT_W = 12;

  // Colour encoding {R,G,B}, shared with the CPU's VGA instruction
  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'b000;
  localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'b001;
  localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'b010;
  localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'b011;
  localparam logic [COLOR_W-1:0] COLOR_RED     = 3'b100;
  localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'b101;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'b110;
  localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - framebuffer read port and video pin bundle
interface vga_scanout_if
  import vga_scanout_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W
);
  logic [ADDR_W-1:0]  oReadAddress;
  logic [COLOR_W-1:0] iReadData;
  logic [COLOR_W-1:0] oRGB;
  logic               oHSync;
  logic               oVSync;
  logic               oFrameStart;

  // Scanout side: drives the read address and the video pins
  modport master (
    output oReadAddress, oRGB, oHSync, oVSync, oFrameStart,
    input  iReadData
  );

  // Framebuffer/pin side
  modport slave (
    input  oReadAddress, oRGB, oHSync, oVSync, oFrameStart,
    output iReadData
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel tick divider and h/v counters with raw sync/active decode
module vga_timing_gen
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             active_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_wrap_o
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             tick, h_last, v_last;

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last = (h_q == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_q == CNT_W'(V_TOTAL - 1));

  // Next-state: divider free-runs, counters step only on the pixel tick
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign tick_o       = tick;
  assign hcount_o     = h_q;
  assign vcount_o     = v_q;
  assign active_o     = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
  assign hs_o         = !((h_q >= CNT_W'(H_VIS + H_FP)) && (h_q < CNT_W'(H_VIS + H_FP + H_SYNC)));
  assign vs_o         = !((v_q >= CNT_W'(V_VIS + V_FP)) && (v_q < CNT_W'(V_VIS + V_FP + V_SYNC)));
  assign frame_wrap_o = tick && h_last && v_last;
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - framebuffer cell fetch and 2-stage RGB/sync output pipeline
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV    = VGA_CLK_DIV,
  parameter int H_VIS      = VGA_H_VIS,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VIS      = VGA_V_VIS,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int CELL_SHIFT = VGA_CELL_SHIFT,
  parameter int COLS       = VGA_COLS,
  parameter int ADDR_W     = VGA_ADDR_W
) (
  input  logic          Clock,
  input  logic          Reset,
  vga_scanout_if.master bus
);
  logic             tick, active, hs, vs, frame_wrap;
  logic [CNT_W-1:0] hcount, vcount;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk_i        (Clock),
    .rst_n_i      (Reset),
    .tick_o       (tick),
    .hcount_o     (hcount),
    .vcount_o     (vcount),
    .active_o     (active),
    .hs_o         (hs),
    .vs_o         (vs),
    .frame_wrap_o (frame_wrap)
  );

  // Stage 1: read address plus delayed decode; stage 2: pins
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               active1_q, active1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               frame_q, frame_d;

  // Pipeline next-state; the address holds through blanking so the RAM sees no churn
  always_comb begin
    addr_d    = addr_q;
    active1_d = active1_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;
    rgb_d     = rgb_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    frame_d   = frame_wrap;
    if (tick) begin
      if (active) begin
        addr_d = ADDR_W'(32'(vcount >> CELL_SHIFT) * 32'(COLS) + 32'(hcount >> CELL_SHIFT));
      end
      active1_d = active;
      hs1_d     = hs;
      vs1_d     = vs;
      rgb_d     = active1_q ? bus.iReadData : '0;
      hsync_d   = hs1_q;
      vsync_d   = vs1_q;
    end
  end

  // Pipeline registers with synchronous active-low reset to idle pin levels
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      addr_q    <= '0;
      active1_q <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      rgb_q     <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      active1_q <= active1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.oReadAddress = addr_q;
  assign bus.oRGB         = rgb_q;
  assign bus.oHSync       = hsync_q;
  assign bus.oVSync       = vsync_q;
  assign bus.oFrameStart  = frame_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout at full and reduced timing
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  typedef struct packed {
    int cd; int hv; int hfp; int hsy; int hbp;
    int vv; int vfp; int vsy; int vbp; int cs; int cols;
  } tm_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] mem [0:2047];
  int n_cmp = 0;
  int n_bad = 0;
  tm_t t_full, t_small;

  vga_scanout_if #(.ADDR_W(16)) bus_full ();
  vga_scanout_if #(.ADDR_W(16)) bus_small ();

  vga_scanout dut_full (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus_full)
  );

  vga_scanout #(
    .CLK_DIV(3), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(40), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .CELL_SHIFT(3), .COLS(8), .ADDR_W(16)
  ) dut_small (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus_small)
  );

  // One-clock synchronous framebuffer RAMs
  always @(posedge clk) begin
    bus_full.iReadData  <= mem[bus_full.oReadAddress[10:0]];
    bus_small.iReadData <= mem[bus_small.oReadAddress[10:0]];
  end

  function automatic int cell_addr(tm_t t, int h, int v);
    return (v >> t.cs) * t.cols + (h >> t.cs);
  endfunction

  // Expected pins after the e-th clock edge following reset release
  function automatic exp_t model(tm_t t, longint e);
    exp_t   r;
    int     ht, vt, h, v;
    longint j, p;
    ht = t.hv + t.hfp + t.hsy + t.hbp;
    vt = t.vv + t.vfp + t.vsy + t.vbp;
    r.addr = 0; r.rgb = 3'd0; r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0;
    j = e / t.cd;
    if (j >= 1) begin
      p = (j - 1) % (ht * vt);
      h = int'(p % ht);
      v = int'(p / ht);
      if (v >= t.vv)      r.addr = cell_addr(t, t.hv - 1, t.vv - 1);
      else if (h >= t.hv) r.addr = cell_addr(t, t.hv - 1, v);
      else                r.addr = cell_addr(t, h, v);
    end
    if (j >= 2) begin
      p = (j - 2) % (ht * vt);
      h = int'(p % ht);
      v = int'(p / ht);
      r.rgb = (h < t.hv && v < t.vv) ? mem[cell_addr(t, h, v)] : 3'd0;
      r.hs  = !(h >= t.hv + t.hfp && h < t.hv + t.hfp + t.hsy);
      r.vs  = !(v >= t.vv + t.vfp && v < t.vv + t.vfp + t.vsy);
    end
    r.fs = (e > 0) && (e % t.cd == 0) && (j % (ht * vt) == 0);
    return r;
  endfunction

  task automatic check(input string tag, input longint e, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, expv);
    end
  endtask

  task automatic check_full(input longint e);
    exp_t x;
    x = model(t_full, e);
    check("full.addr", e, 32'(bus_full.oReadAddress), x.addr);
    check("full.rgb",  e, 32'(bus_full.oRGB),         32'(x.rgb));
    check("full.hs",   e, 32'(bus_full.oHSync),       32'(x.hs));
    check("full.vs",   e, 32'(bus_full.oVSync),       32'(x.vs));
    check("full.fs",   e, 32'(bus_full.oFrameStart),  32'(x.fs));
  endtask

  task automatic check_small(input longint e);
    exp_t x;
    x = model(t_small, e);
    check("small.addr", e, 32'(bus_small.oReadAddress), x.addr);
    check("small.rgb",  e, 32'(bus_small.oRGB),         32'(x.rgb));
    check("small.hs",   e, 32'(bus_small.oHSync),       32'(x.hs));
    check("small.vs",   e, 32'(bus_small.oVSync),       32'(x.vs));
    check("small.fs",   e, 32'(bus_small.oFrameStart),  32'(x.fs));
  endtask

  // Free-run for n edges after release, checking both instances each clock
  task automatic run_segment(input int n);
    for (longint e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      check_small(e);
      if (e < 3400) check_full(e);
    end
  endtask

  // Hold reset for n edges, checking idle outputs after each
  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_small(0);
      check_full(0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    t_full  = '{cd: 2, hv: 640, hfp: 16, hsy: 96, hbp: 48,
                vv: 480, vfp: 10, vsy: 2, vbp: 33, cs: 4, cols: 40};
    t_small = '{cd: 3, hv: 64, hfp: 4, hsy: 8, hbp: 4,
                vv: 40, vfp: 3, vsy: 2, vbp: 5, cs: 3, cols: 8};
    for (int i = 0; i < 2048; i++) mem[i] = 3'($urandom);

    // Power-up reset, five clocks
    @(posedge clk);
    #1;
    hold_reset(5);

    // Two small frames (12000 clocks each) plus a random mid-frame offset
    run_segment(24000 + int'($urandom_range(2000, 9000)));

    // Mid-frame reset for a random number of clocks, then a clean restart
    hold_reset(int'($urandom_range(1, 4)));
    run_segment(13500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
